// File: rtl/pp_reader_pkg.sv
// pp_reader_pkg: shared types for the ping-pong FIFO pixel reader.
//   state_t        reader FSM states (fixed encodings kept from the legacy localparams)
//   rgb565_t       camera pixel as stored in the line FIFOs
//   rgb888_t       expanded pixel presented to consumers
//   marker_t       line/frame markers that travel with each pixel
//   rgb565_to_888  bit-replicating colour expansion
package pp_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } marker_t;

  // Replicating the top bits into the new LSBs maps full scale to 8'hFF.
  function automatic rgb888_t rgb565_to_888(input rgb565_t p);
    rgb888_t q;
    q.r = {p.r, p.r[4:2]};
    q.g = {p.g, p.g[5:4]};
    q.b = {p.b, p.b[4:2]};
    return q;
  endfunction

endpackage

// File: rtl/pp_fifo_pixel_reader_skid.sv
// pp_skid_buf: 2-entry valid/ready buffer.
//   clk, rst      clock, asynchronous active-high reset
//   flush         empties the buffer (takes priority over push/pop)
//   in_data/vld   write side; writer guarantees space (credit-based)
//   out_data/vld  head entry; out_rdy pops it
//   occupancy     number of stored entries (0..2)
module pp_skid_buf #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_vld,
  output logic [W-1:0] out_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [1:0]   occupancy
);

  logic [W-1:0] head, tail;
  logic [1:0]   cnt;
  logic         pop;

  assign pop       = out_vld && out_rdy;
  assign out_vld   = (cnt != 2'd0);
  assign out_data  = head;
  assign occupancy = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({in_vld, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= in_data;
          else             tail <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pp_fifo_pixel_reader.sv
// pp_fifo_pixel_reader: drains the even/odd line FIFOs (fifo1/fifo2) in strict
// alternation, expands RGB565 to RGB888 and emits a valid/ready pixel stream
// with sol/eol/sof/eof markers.
//   clk, rst                     clock, asynchronous active-high reset
//   i_frame_sync                 frame start pulse (resync when not idle)
//   i_fifo1_empty/i_fifo2_empty  FIFO empty flags
//   o_fifo1_rd_en/o_fifo2_rd_en  FIFO read strobes (1-cycle read latency)
//   i_fifo_rd_data/i_fifo_rd_vld read response of the strobed FIFO
//   o_pix/o_pix_vld/i_pix_rdy    RGB888 output stream
//   o_sol/o_eol/o_sof/o_eof      markers, qualified by o_pix_vld
//   o_fifo_sel                   0 = draining fifo1, 1 = fifo2
// Optional: define PP_READER_STAT_EN to add o_underrun_cnt / o_frame_cnt.
module pp_fifo_pixel_reader
  import pp_reader_pkg::*;
#(
  parameter int LINE_PIX    = 800,
  parameter int FRAME_LINES = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_sync,
  input  logic        i_fifo1_empty,
  input  logic        i_fifo2_empty,
  output logic        o_fifo1_rd_en,
  output logic        o_fifo2_rd_en,
  input  logic [15:0] i_fifo_rd_data,
  input  logic        i_fifo_rd_vld,
  output logic [23:0] o_pix,
  output logic        o_pix_vld,
  input  logic        i_pix_rdy,
  output logic        o_sol,
  output logic        o_eol,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_fifo_sel
`ifdef PP_READER_STAT_EN
  ,
  output logic [15:0] o_underrun_cnt,
  output logic [15:0] o_frame_cnt
`endif
);

  localparam int CW = $clog2(LINE_PIX);
  localparam int LW = $clog2(FRAME_LINES);

  state_t        state;
  logic          fifo_sel;
  logic [CW-1:0] rd_cnt;    // reads issued in current line
  logic [CW-1:0] col;       // responses received in current line
  logic [LW-1:0] line;
  logic [1:0]    inflight;  // reads whose data has not yet returned
  logic [1:0]    discard;   // stale responses still owed after a resync
  logic [1:0]    occ;

  logic          resync, sel_empty, pop, rd_issue, resp_ok, resp_drop;
  logic          last_rd, last_col, last_line;
  logic [2:0]    used;
  logic [1:0]    inflight_nxt;
  marker_t       mk;
  logic [27:0]   buf_in, buf_out;

  assign resync    = i_frame_sync && (state != ST_IDLE);
  assign sel_empty = fifo_sel ? i_fifo2_empty : i_fifo1_empty;
  assign pop       = o_pix_vld && i_pix_rdy;
  // A pop this cycle frees a slot in time for the read issued now.
  assign used      = {1'b0, occ} + {1'b0, inflight} - {2'b00, pop};
  assign rd_issue  = (state == ST_READ) && !resync && !sel_empty && (used < 3'd2);

  assign o_fifo1_rd_en = rd_issue && !fifo_sel;
  assign o_fifo2_rd_en = rd_issue &&  fifo_sel;
  assign o_fifo_sel    = fifo_sel;

  assign resp_drop    = i_fifo_rd_vld && (discard != 2'd0);
  assign resp_ok      = i_fifo_rd_vld && (discard == 2'd0) && (inflight != 2'd0);
  assign inflight_nxt = inflight + {1'b0, rd_issue} - {1'b0, resp_ok};

  assign last_rd   = (rd_cnt == CW'(LINE_PIX - 1));
  assign last_col  = (col == CW'(LINE_PIX - 1));
  assign last_line = (line == LW'(FRAME_LINES - 1));

  always_comb begin
    mk     = '0;
    mk.sol = (col == '0);
    mk.eol = last_col;
    mk.sof = (line == '0) && (col == '0);
    mk.eof = last_line && last_col;
  end

  assign buf_in = {mk, rgb565_to_888(i_fifo_rd_data)};

  pp_skid_buf #(.W(28)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (resync),
    .in_data   (buf_in),
    .in_vld    (resp_ok),
    .out_data  (buf_out),
    .out_vld   (o_pix_vld),
    .out_rdy   (i_pix_rdy),
    .occupancy (occ)
  );

  assign o_pix = buf_out[23:0];
  assign o_sol = buf_out[27];
  assign o_eol = buf_out[26];
  assign o_sof = buf_out[25];
  assign o_eof = buf_out[24];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      fifo_sel <= 1'b0;
      rd_cnt   <= '0;
      col      <= '0;
      line     <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (i_frame_sync) begin
      state    <= ST_READ;
      fifo_sel <= 1'b0;
      rd_cnt   <= '0;
      col      <= '0;
      line     <= '0;
      inflight <= '0;
      // Reads still outstanding at the resync are owed back and dropped on arrival.
      discard  <= discard + inflight - {1'b0, resp_drop} - {1'b0, resp_ok};
    end else begin
      inflight <= inflight_nxt;
      if (resp_drop) discard <= discard - 2'd1;
      if (resp_ok)   col     <= last_col ? '0 : col + CW'(1);
      case (state)
        ST_READ: begin
          if (rd_issue) begin
            rd_cnt <= last_rd ? '0 : rd_cnt + CW'(1);
            if (last_rd) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (inflight_nxt == 2'd0) begin
            if (last_line) begin
              state    <= ST_IDLE;
              fifo_sel <= 1'b0;
              line     <= '0;
            end else begin
              state    <= ST_READ;
              fifo_sel <= ~fifo_sel;
              line     <= line + LW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PP_READER_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_underrun_cnt <= '0;
      o_frame_cnt    <= '0;
    end else begin
      if ((state == ST_READ) && sel_empty && (o_underrun_cnt != '1))
        o_underrun_cnt <= o_underrun_cnt + 16'd1;
      if (!i_frame_sync && (state == ST_DRAIN) && (inflight_nxt == 2'd0) && last_line)
        o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end
`else
  // statistics counters not built
`endif

endmodule

// File: tb/tb_pp_fifo_pixel_reader.sv
module tb_pp_fifo_pixel_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_frame_sync;
  logic        i_fifo1_empty, i_fifo2_empty;
  logic        o_fifo1_rd_en, o_fifo2_rd_en;
  logic [15:0] i_fifo_rd_data;
  logic        i_fifo_rd_vld;
  logic [23:0] o_pix;
  logic        o_pix_vld, i_pix_rdy;
  logic        o_sol, o_eol, o_sof, o_eof, o_fifo_sel;

  always #5 clk = ~clk;

  pp_fifo_pixel_reader #(.LINE_PIX(4), .FRAME_LINES(2)) dut (
    .clk(clk), .rst(rst), .i_frame_sync(i_frame_sync),
    .i_fifo1_empty(i_fifo1_empty), .i_fifo2_empty(i_fifo2_empty),
    .o_fifo1_rd_en(o_fifo1_rd_en), .o_fifo2_rd_en(o_fifo2_rd_en),
    .i_fifo_rd_data(i_fifo_rd_data), .i_fifo_rd_vld(i_fifo_rd_vld),
    .o_pix(o_pix), .o_pix_vld(o_pix_vld), .i_pix_rdy(i_pix_rdy),
    .o_sol(o_sol), .o_eol(o_eol), .o_sof(o_sof), .o_eof(o_eof),
    .o_fifo_sel(o_fifo_sel)
  );

  int total = 0;
  int bad = 0;

  // FIFO contents and read pointers (pointers owned by the FIFO model)
  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];
  logic [7:0]  rp1 = 8'd0;
  logic [7:0]  rp2 = 8'd0;

  // FIFO model: 1-cycle read latency
  initial begin
    i_fifo_rd_vld  <= 1'b0;
    i_fifo_rd_data <= 16'h0;
    forever begin
      @(posedge clk);
      i_fifo_rd_vld <= o_fifo1_rd_en | o_fifo2_rd_en;
      if (o_fifo1_rd_en) begin
        i_fifo_rd_data <= mem1[rp1];
        rp1 = rp1 + 8'd1;
      end else if (o_fifo2_rd_en) begin
        i_fifo_rd_data <= mem2[rp2];
        rp2 = rp2 + 8'd1;
      end
    end
  end

  // Monitor state
  logic        mon_clr = 1'b0;
  logic [27:0] pixq [$];
  bit          rdq [$];
  int          iss, xfer, max_out, both_cnt, empty_cnt, unstable_cnt;
  bit          stall_prev;
  logic [27:0] stall_val;

  initial begin
    iss = 0; xfer = 0; max_out = 0; both_cnt = 0; empty_cnt = 0; unstable_cnt = 0;
    stall_prev = 0; stall_val = '0;
    forever begin
      @(negedge clk);
      if (mon_clr || rst) begin
        pixq.delete(); rdq.delete();
        iss = 0; xfer = 0; max_out = 0; both_cnt = 0; empty_cnt = 0; unstable_cnt = 0;
        stall_prev = 0;
      end else begin
        if (o_fifo1_rd_en && o_fifo2_rd_en) both_cnt++;
        if ((o_fifo1_rd_en && i_fifo1_empty) || (o_fifo2_rd_en && i_fifo2_empty)) empty_cnt++;
        if (stall_prev && (!o_pix_vld || {o_sol, o_eol, o_sof, o_eof, o_pix} !== stall_val))
          unstable_cnt++;
        stall_prev = o_pix_vld && !i_pix_rdy;
        stall_val  = {o_sol, o_eol, o_sof, o_eof, o_pix};
        if (o_fifo1_rd_en) rdq.push_back(1'b0);
        if (o_fifo2_rd_en) rdq.push_back(1'b1);
        if (o_fifo1_rd_en || o_fifo2_rd_en) iss++;
        if (o_pix_vld && i_pix_rdy) begin
          pixq.push_back({o_sol, o_eol, o_sof, o_eof, o_pix});
          xfer++;
        end
        if (iss - xfer > max_out) max_out = iss - xfer;
      end
    end
  end

  function automatic logic [23:0] exp888(input logic [15:0] w);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(w[15:11]); g6 = int'(w[10:5]); b5 = int'(w[4:0]);
    r8 = (r5 << 3) | (r5 >> 2);
    g8 = (g6 << 2) | (g6 >> 4);
    b8 = (b5 << 3) | (b5 >> 2);
    return {r8[7:0], g8[7:0], b8[7:0]};
  endfunction

  // Expected {sol,eol,sof,eof,pix} of frame pixel i (4 px/line, 2 lines)
  function automatic logic [27:0] exp_entry(input int i, input logic [7:0] b1, input logic [7:0] b2);
    int col, ln;
    logic [7:0] idx;
    logic [15:0] w;
    col = i % 4; ln = (i / 4) % 2;
    idx = (ln == 0 ? b1 : b2) + 8'(col);
    w = (ln == 0) ? mem1[idx] : mem2[idx];
    return {col == 0, col == 3, i == 0, i == 7, exp888(w)};
  endfunction

  function automatic logic [27:0] got_at(input int i);
    return (i < pixq.size()) ? pixq[i] : 28'hxxxxxxx;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic pulse_sync();
    i_frame_sync = 1'b1;
    step(1);
    i_frame_sync = 1'b0;
  endtask

  task automatic wait_pix(input int n, input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (pixq.size() >= n) begin to = 1'b0; break; end
      step(1);
    end
    if (pixq.size() >= n) to = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    total++;
    if ({o_pix, o_pix_vld, o_sol, o_eol, o_sof, o_eof} !== 30'h0) begin
      bad++; $display("FAIL reset_out got=%h exp=0", {o_pix, o_pix_vld, o_sol, o_eol, o_sof, o_eof});
    end
    total++;
    if ({o_fifo1_rd_en, o_fifo2_rd_en, o_fifo_sel} !== 3'b000) begin
      bad++; $display("FAIL reset_ctl got=%b exp=000", {o_fifo1_rd_en, o_fifo2_rd_en, o_fifo_sel});
    end
    rst = 1'b0;
    clr_mon();
    step(5);
    total++;
    if (rdq.size() != 0) begin
      bad++; $display("FAIL idle_no_rd got=%0d exp=0", rdq.size());
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] b1, b2;
    bit to;
    clr_mon();
    b1 = rp1; b2 = rp2;
    pulse_sync();
    wait_pix(8, 100, to);
    total++;
    if (to) begin bad++; $display("FAIL t1_timeout got=%0d exp=8", pixq.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got_at(i) !== exp_entry(i, b1, b2)) begin
        bad++; $display("FAIL t1_pix%0d got=%h exp=%h", i, got_at(i), exp_entry(i, b1, b2));
      end
    end
    step(10);
    total++;
    if (rdq.size() != 8) begin bad++; $display("FAIL t1_rd_count got=%0d exp=8", rdq.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if ((i < rdq.size() ? rdq[i] : 1'bx) !== (i >= 4)) begin
        bad++; $display("FAIL t1_rd_sel%0d got=%b exp=%b", i, (i < rdq.size() ? rdq[i] : 1'bx), i >= 4);
      end
    end
    total++;
    if (pixq.size() != 8 || o_fifo_sel !== 1'b0) begin
      bad++; $display("FAIL t1_idle got=%0d/%b exp=8/0", pixq.size(), o_fifo_sel);
    end
  endtask

  task automatic test_expansion();
    logic [15:0] win [4];
    logic [23:0] wexp [4];
    bit to;
    win[0] = 16'hF800; win[1] = 16'h07E0; win[2] = 16'h001F; win[3] = 16'h8410;
    wexp[0] = 24'hFF0000; wexp[1] = 24'h00FF00; wexp[2] = 24'h0000FF; wexp[3] = 24'h848284;
    for (int i = 0; i < 4; i++) mem1[rp1 + 8'(i)] = win[i];
    clr_mon();
    pulse_sync();
    wait_pix(8, 100, to);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_at(i)[23:0] !== wexp[i]) begin
        bad++; $display("FAIL t2_exp_%h got=%h exp=%h", win[i], got_at(i)[23:0], wexp[i]);
      end
    end
    step(5);
  endtask

  task automatic test_backpressure();
    logic [7:0] b1, b2;
    bit pat [4];
    int c;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    clr_mon();
    b1 = rp1; b2 = rp2;
    i_pix_rdy = 1'b1;
    pulse_sync();
    c = 1;
    while (pixq.size() < 8 && c < 200) begin
      i_pix_rdy = pat[c % 4];
      step(1);
      c++;
    end
    i_pix_rdy = 1'b1;
    step(10);
    total++;
    if (pixq.size() != 8) begin bad++; $display("FAIL t3_count got=%0d exp=8", pixq.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got_at(i) !== exp_entry(i, b1, b2)) begin
        bad++; $display("FAIL t3_pix%0d got=%h exp=%h", i, got_at(i), exp_entry(i, b1, b2));
      end
    end
    total++;
    if (max_out > 2) begin bad++; $display("FAIL t3_outstanding got=%0d exp<=2", max_out); end
    total++;
    if (unstable_cnt != 0) begin bad++; $display("FAIL t3_stall_stable got=%0d exp=0", unstable_cnt); end
  endtask

  task automatic test_empty_gaps();
    logic [7:0] b1, b2;
    int c;
    clr_mon();
    b1 = rp1; b2 = rp2;
    pulse_sync();
    c = 0;
    while (pixq.size() < 8 && c < 200) begin
      i_fifo1_empty = ~i_fifo1_empty;
      step(1);
      c++;
    end
    i_fifo1_empty = 1'b0;
    step(5);
    total++;
    if (empty_cnt != 0) begin bad++; $display("FAIL t4_rd_empty got=%0d exp=0", empty_cnt); end
    total++;
    if (both_cnt != 0) begin bad++; $display("FAIL t4_both_rd got=%0d exp=0", both_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got_at(i) !== exp_entry(i, b1, b2)) begin
        bad++; $display("FAIL t4_pix%0d got=%h exp=%h", i, got_at(i), exp_entry(i, b1, b2));
      end
    end
  endtask

  task automatic test_resync();
    logic [7:0] b1, b2;
    int n;
    bit to;
    clr_mon();
    pulse_sync();
    wait_pix(6, 100, to);
    total++;
    if (to) begin bad++; $display("FAIL t5_pre_timeout got=%0d exp=6", pixq.size()); end
    pulse_sync();
    n = pixq.size();
    b1 = rp1; b2 = rp2;
    total++;
    if (o_pix_vld !== 1'b0) begin bad++; $display("FAIL t5_flush_vld got=%b exp=0", o_pix_vld); end
    wait_pix(n + 8, 100, to);
    total++;
    if (to) begin bad++; $display("FAIL t5_post_timeout got=%0d exp=%0d", pixq.size(), n + 8); end
    total++;
    if (got_at(n)[25] !== 1'b1 || got_at(n)[23] !== 1'b0) begin
      bad++; $display("FAIL t5_first_sof_fifo1 got=%h exp_sof=1 exp_tag=0", got_at(n));
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got_at(n + i) !== exp_entry(i, b1, b2)) begin
        bad++; $display("FAIL t5_pix%0d got=%h exp=%h", i, got_at(n + i), exp_entry(i, b1, b2));
      end
    end
    step(5);
  endtask

  task automatic test_reset_midline();
    bit to;
    clr_mon();
    i_pix_rdy = 1'b0;
    pulse_sync();
    step(6);
    total++;
    if (o_pix_vld !== 1'b1) begin bad++; $display("FAIL t6_pre_vld got=%b exp=1", o_pix_vld); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({o_pix, o_pix_vld, o_sol, o_eol, o_sof, o_eof, o_fifo1_rd_en, o_fifo2_rd_en, o_fifo_sel} !== 33'h0) begin
      bad++; $display("FAIL t6_async_clear got=%h exp=0",
                      {o_pix, o_pix_vld, o_sol, o_eol, o_sof, o_eof, o_fifo1_rd_en, o_fifo2_rd_en, o_fifo_sel});
    end
    step(2);
    rst = 1'b0;
    i_pix_rdy = 1'b1;
    clr_mon();
    step(10);
    total++;
    if (rdq.size() != 0 || pixq.size() != 0) begin
      bad++; $display("FAIL t6_quiet got=%0d/%0d exp=0/0", rdq.size(), pixq.size());
    end
    pulse_sync();
    wait_pix(8, 100, to);
    total++;
    if (to || rdq.size() == 0 || rdq[0] !== 1'b0) begin
      bad++; $display("FAIL t6_restart got=%0d pix exp=8", pixq.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    i_frame_sync = 1'b0;
    i_fifo1_empty = 1'b0;
    i_fifo2_empty = 1'b0;
    i_pix_rdy = 1'b1;
    for (int p = 0; p < 256; p++) begin
      mem1[p] = 16'((p * 16'h0123) & 16'h7FFF);
      mem2[p] = 16'h8000 | 16'((p * 16'h0321) & 16'h7FFF);
    end
    test_reset();
    test_basic_frame();
    test_expansion();
    test_backpressure();
    test_empty_gaps();
    test_resync();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
